// File: rtl/a25_cache_flush_ctrl_if.sv
// Signal bundle between CP15/core and the cache flush sequencer.
// Exposes the sequencer state on dbg_state for checkers.
interface a25_cache_flush_ctrl_if #(
    parameter int LINES = 256,
    parameter int WAYS  = 4,
    parameter int TAG_W = 21
);
    localparam int IW = $clog2(LINES);

    logic             i_core_stall;
    logic             i_cache_enable;
    logic             i_cache_flush;
    logic [31:0]      i_cacheable_area;
    logic [31:0]      i_address;
    logic             i_address_valid;
    logic             o_flush_busy;
    logic             o_flush_done;
    logic             o_tag_wr_en;
    logic [IW-1:0]    o_tag_wr_addr;
    logic [WAYS-1:0]  o_tag_wr_way_mask;
    logic [TAG_W-1:0] o_tag_wr_data;
    logic             o_cacheable;
    logic [1:0]       dbg_state;

    modport master (
        output i_core_stall, i_cache_enable, i_cache_flush, i_cacheable_area,
               i_address, i_address_valid,
        input  o_flush_busy, o_flush_done, o_tag_wr_en, o_tag_wr_addr,
               o_tag_wr_way_mask, o_tag_wr_data, o_cacheable, dbg_state
    );

    modport slave (
        input  i_core_stall, i_cache_enable, i_cache_flush, i_cacheable_area,
               i_address, i_address_valid,
        output o_flush_busy, o_flush_done, o_tag_wr_en, o_tag_wr_addr,
               o_tag_wr_way_mask, o_tag_wr_data, o_cacheable, dbg_state
    );
endinterface

// File: rtl/a25_cache_flush_ctrl.sv
// Cache flush sequencer: walks every set invalidating all ways, plus the registered cacheable decode.
// Optional A25_FLUSH_ON_RESET_EN: start in FLUSH after reset so tags are clean at boot.
module a25_cache_flush_ctrl #(
    parameter int LINES = 256,
    parameter int WAYS  = 4,
    parameter int TAG_W = 21
) (
    input  logic                   i_clk,
    input  logic                   i_rst,
    a25_cache_flush_ctrl_if.slave  bus
);
    localparam int IW = $clog2(LINES);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FLUSH = 2'd1,
        ST_DONE  = 2'd2
    } state_e;

`ifdef A25_FLUSH_ON_RESET_EN
    localparam state_e RST_STATE = ST_FLUSH;
`else
    localparam state_e RST_STATE = ST_IDLE;
`endif

    state_e        state_q, state_d;
    logic [IW-1:0] idx_q, idx_d;
    logic          pending_q, pending_d;
    logic          wr_en_q, wr_en_d;
    logic          busy_q, busy_d;
    logic          done_q, done_d;
    logic [IW-1:0] addr_q, addr_d;
    logic          cacheable_q, cacheable_d;

    logic          flush_active;
    logic          last_idx;
    logic          unused_addr_bits;

    assign flush_active     = (state_q == ST_FLUSH) || bus.i_cache_flush;
    assign last_idx         = (idx_q == IW'(LINES - 1));
    assign unused_addr_bits = ^{bus.i_address[31:26], bus.i_address[20:0]};

    // state_q/idx_q always describe what the output registers present this
    // cycle; the only exception is the reset-into-FLUSH case, where wr_en_q is
    // still low and set 0 has not yet been presented.
    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        pending_d = pending_q;
        case (state_q)
            ST_IDLE: begin
                if (bus.i_cache_flush) begin
                    state_d = ST_FLUSH;
                    idx_d   = '0;
                end
            end
            ST_FLUSH: begin
                if (bus.i_cache_flush) begin
                    pending_d = 1'b1;
                end
                if (!wr_en_q) begin
                    idx_d = idx_q;
                end else if (last_idx) begin
                    state_d = ST_DONE;
                    idx_d   = '0;
                end else begin
                    idx_d = idx_q + 1'b1;
                end
            end
            ST_DONE: begin
                // A strobe landing in DONE folds into the pending restart.
                if (pending_q || bus.i_cache_flush) begin
                    pending_d = 1'b0;
                    state_d   = ST_FLUSH;
                    idx_d     = '0;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
                idx_d   = '0;
            end
        endcase
    end

    always_comb begin
        wr_en_d = (state_d == ST_FLUSH);
        busy_d  = (state_d == ST_FLUSH);
        done_d  = (state_d == ST_DONE);
        addr_d  = (state_d == ST_FLUSH) ? idx_d : '0;
    end

    // An access is accepted when i_address_valid is high and i_core_stall is
    // low in the same cycle; there is no back-pressure, stall just freezes it.
    always_comb begin
        cacheable_d = cacheable_q;
        if (!bus.i_core_stall && bus.i_address_valid) begin
            cacheable_d = bus.i_cache_enable
                       && bus.i_cacheable_area[bus.i_address[25:21]]
                       && !flush_active;
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q     <= RST_STATE;
            idx_q       <= '0;
            pending_q   <= 1'b0;
            wr_en_q     <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            addr_q      <= '0;
            cacheable_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            pending_q   <= pending_d;
            wr_en_q     <= wr_en_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            addr_q      <= addr_d;
            cacheable_q <= cacheable_d;
        end
    end

    assign bus.o_flush_busy      = busy_q;
    assign bus.o_flush_done      = done_q;
    assign bus.o_tag_wr_en       = wr_en_q;
    assign bus.o_tag_wr_addr     = addr_q;
    assign bus.o_tag_wr_way_mask = {WAYS{wr_en_q}};
    assign bus.o_tag_wr_data     = '0;
    assign bus.o_cacheable       = cacheable_q;
    assign bus.dbg_state         = state_q;
endmodule

// File: tb/tb_a25_cache_flush_ctrl.sv
// Randomised scoreboard bench for a25_cache_flush_ctrl with a walk-schedule reference model.
// Honours A25_FLUSH_ON_RESET_EN when it is defined for the build.
module tb_a25_cache_flush_ctrl;
    localparam int LINES = 256;
    localparam int WAYS  = 4;
    localparam int TAG_W = 21;
    localparam int IW    = 8;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    a25_cache_flush_ctrl_if #(.LINES(LINES), .WAYS(WAYS), .TAG_W(TAG_W)) bus ();

    a25_cache_flush_ctrl #(.LINES(LINES), .WAYS(WAYS), .TAG_W(TAG_W)) dut (
        .i_clk (clk),
        .i_rst (rst),
        .bus   (bus)
    );

    int total = 0;
    int bad   = 0;

    logic [IW+31:0] exp_wr_q[$];
    logic [31:0]    exp_done_q[$];
    logic [32:0]    exp_cache_q[$];
    int             starts[$];
    logic           exp_cache_val = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s cyc=%0d actual=%0h expected=%0h", name, cyc, act, exp);
        end
    endtask

    // Reference model: each flush is a walk of LINES write cycles starting at s
    // followed by a done pulse at s+LINES.
    function automatic void schedule_walk(int s);
        starts.push_back(s);
        for (int i = 0; i < LINES; i++) exp_wr_q.push_back({32'(s + i), IW'(i)});
        exp_done_q.push_back(32'(s + LINES));
    endfunction

    function automatic void model_strobe(int n);
        if (starts.size() == 0 || n > starts[$] + LINES) schedule_walk(n + 1);
        else if (n >= starts[$]) schedule_walk(starts[$] + LINES + 1);
    endfunction

    function automatic bit model_busy(int n);
        foreach (starts[k]) if (n >= starts[k] && n < starts[k] + LINES) return 1'b1;
        return 1'b0;
    endfunction

    function automatic void model_clear();
        exp_wr_q.delete();
        exp_done_q.delete();
        exp_cache_q.delete();
        starts.delete();
        exp_cache_val = 1'b0;
    endfunction

    task automatic drive(input logic fl, input logic vld, input logic stl, input logic en,
                         input logic [31:0] area, input logic [31:0] addr);
        @(posedge clk);
        #1;
        bus.i_cache_flush    = fl;
        bus.i_address_valid  = vld;
        bus.i_core_stall     = stl;
        bus.i_cache_enable   = en;
        bus.i_cacheable_area = area;
        bus.i_address        = addr;
        if (vld && !stl)
            exp_cache_q.push_back({32'(cyc + 1), en && area[addr[25:21]] && !(model_busy(cyc) || fl)});
        if (fl) model_strobe(cyc);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drive(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    endtask

    task automatic wait_model_idle();
        int guard;
        guard = 0;
        while (starts.size() > 0 && cyc <= starts[$] + LINES && guard < 3000) begin
            idle(1);
            guard++;
        end
        if (guard >= 3000) chk("idle_timeout", 32'(guard), 32'd0);
    endtask

    task automatic release_reset();
        rst = 1'b0;
`ifdef A25_FLUSH_ON_RESET_EN
        schedule_walk(cyc + 1);
`endif
    endtask

    task automatic check_outputs_zero(input string tag);
        chk({tag, "_busy"}, 32'(bus.o_flush_busy), 32'd0);
        chk({tag, "_done"}, 32'(bus.o_flush_done), 32'd0);
        chk({tag, "_wr_en"}, 32'(bus.o_tag_wr_en), 32'd0);
        chk({tag, "_wr_addr"}, 32'(bus.o_tag_wr_addr), 32'd0);
        chk({tag, "_cacheable"}, 32'(bus.o_cacheable), 32'd0);
    endtask

    // Monitor: pops expected events whenever the DUT presents one.
    always @(negedge clk) begin
        if (!rst) begin
            while (exp_wr_q.size() > 0 && exp_wr_q[0][IW+31:IW] < 32'(cyc)) begin
                chk("wr_missing_cycle", 32'(cyc), exp_wr_q[0][IW+31:IW]);
                void'(exp_wr_q.pop_front());
            end
            if (bus.o_tag_wr_en) begin
                if (exp_wr_q.size() == 0 || exp_wr_q[0][IW+31:IW] != 32'(cyc)) begin
                    chk("wr_unexpected", 32'd1, 32'd0);
                end else begin
                    chk("wr_addr", 32'(bus.o_tag_wr_addr), 32'(exp_wr_q[0][IW-1:0]));
                    void'(exp_wr_q.pop_front());
                end
                chk("wr_way_mask", 32'(bus.o_tag_wr_way_mask), 32'hF);
                chk("wr_data", 32'(bus.o_tag_wr_data), 32'd0);
            end
            chk("busy", 32'(bus.o_flush_busy), 32'(model_busy(cyc)));

            while (exp_done_q.size() > 0 && exp_done_q[0] < 32'(cyc)) begin
                chk("done_missing_cycle", 32'(cyc), exp_done_q[0]);
                void'(exp_done_q.pop_front());
            end
            if (bus.o_flush_done) begin
                if (exp_done_q.size() == 0 || exp_done_q[0] != 32'(cyc)) begin
                    chk("done_unexpected", 32'd1, 32'd0);
                end else begin
                    chk("done_cycle", 32'(cyc), exp_done_q[0]);
                    void'(exp_done_q.pop_front());
                end
            end

            while (exp_cache_q.size() > 0 && exp_cache_q[0][32:1] <= 32'(cyc)) begin
                exp_cache_val = exp_cache_q[0][0];
                void'(exp_cache_q.pop_front());
            end
            chk("cacheable", 32'(bus.o_cacheable), 32'(exp_cache_val));
        end
    end

    initial begin
        int s;
        int done2;
        int guard;
        bus.i_cache_flush    = 1'b0;
        bus.i_address_valid  = 1'b0;
        bus.i_core_stall     = 1'b0;
        bus.i_cache_enable   = 1'b0;
        bus.i_cacheable_area = 32'h0;
        bus.i_address        = 32'h0;

        repeat (3) @(posedge clk);
        #1;
        check_outputs_zero("reset");
        #1;
        release_reset();
        wait_model_idle();

        // Strobe, second strobe mid-walk, then one exactly in the DONE cycle.
        drive(1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
        idle(89);
        drive(1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
        done2 = starts[$] + LINES;
        guard = 0;
        while (cyc + 1 < done2 && guard < 1000) begin
            idle(1);
            guard++;
        end
        drive(1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
        idle(10);
        drive(1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
        drive(1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
        wait_model_idle();

        // Directed cacheable decode.
        drive(1'b0, 1'b1, 1'b0, 1'b1, 32'h0000_0004, 32'h0040_0010);
        idle(1);
        @(negedge clk);
        chk("dir_cacheable_hit", 32'(bus.o_cacheable), 32'd1);
        drive(1'b0, 1'b1, 1'b0, 1'b1, 32'h0000_0004, 32'h0020_0000);
        idle(1);
        @(negedge clk);
        chk("dir_cacheable_miss", 32'(bus.o_cacheable), 32'd0);
        drive(1'b0, 1'b1, 1'b0, 1'b1, 32'h0000_0004, 32'hFC40_0010);
        drive(1'b0, 1'b1, 1'b1, 1'b1, 32'h0000_0004, 32'h0020_0000);
        idle(1);
        @(negedge clk);
        chk("dir_cacheable_stall_hold", 32'(bus.o_cacheable), 32'd1);
        drive(1'b1, 1'b1, 1'b0, 1'b1, 32'h0000_0004, 32'h0040_0010);
        idle(1);
        @(negedge clk);
        chk("dir_cacheable_strobe", 32'(bus.o_cacheable), 32'd0);
        idle(5);
        drive(1'b0, 1'b1, 1'b0, 1'b1, 32'h0000_0004, 32'h0040_0010);
        idle(1);
        @(negedge clk);
        chk("dir_cacheable_walk", 32'(bus.o_cacheable), 32'd0);
        wait_model_idle();

        // Random traffic.
        for (int i = 0; i < 2500; i++) begin
            drive($urandom_range(0, 149) == 0, 1'($urandom_range(0, 1)),
                  $urandom_range(0, 3) == 0, $urandom_range(0, 3) != 0,
                  $urandom, $urandom);
        end
        wait_model_idle();

        // Reset in the middle of a walk, at index 50.
        drive(1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
        s = starts[$];
        guard = 0;
        while (cyc + 1 < s + 50 && guard < 1000) begin
            idle(1);
            guard++;
        end
        @(posedge clk);
        #2;
        chk("pre_reset_addr", 32'(bus.o_tag_wr_addr), 32'd50);
        rst = 1'b1;
        model_clear();
        #1;
        check_outputs_zero("async_reset");
        repeat (2) @(posedge clk);
        #2;
        release_reset();
        idle(40);
        wait_model_idle();
        idle(5);

        chk("wr_queue_drained", 32'(exp_wr_q.size()), 32'd0);
        chk("done_queue_drained", 32'(exp_done_q.size()), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/a25_cache_flush_ctrl.md
# a25_cache_flush_ctrl

Cache maintenance sequencer for the Amber 25 core, downstream of co-processor 15. It consumes the single-cycle cache-flush strobe and the cache-enable / cacheable-area outputs of CP15. It walks every cache set to invalidate all tag entries, holding the core off with a busy signal. It also produces the registered per-access "cacheable" decision used by the cache.

## Interface
Parameters:
- `LINES`, 256: cache sets per way; power of two, 2..1024; index width `IW = $clog2(LINES)`.
- `WAYS`, 4: cache ways; every flush write covers all ways.
- `TAG_W`, 21: tag-RAM entry width, including the valid bit.

Ports:
- `i_clk`  in  1  system clock.
- `i_rst`  in  1  reset, asynchronous, active-high.
- `i_core_stall`  in  1  core-wide stall; freezes the cacheable decode only.
- `i_cache_enable`  in  1  CP15 cache-control bit 0.
- `i_cache_flush`  in  1  CP15 flush strobe, one cycle per MCR to CP15 register 1.
- `i_cacheable_area`  in  32  CP15 cacheable-region mask, 1 bit per 2 MB region.
- `i_address`  in  32  core access address.
- `i_address_valid`  in  1  core access request.
- `o_flush_busy`  out  1  flush walk in progress; cache must stall the core.
- `o_flush_done`  out  1  one-cycle pulse when a walk completes.
- `o_tag_wr_en`  out  1  tag-RAM write strobe.
- `o_tag_wr_addr`  out  IW  set index being invalidated.
- `o_tag_wr_way_mask`  out  WAYS  ways written; all ones whenever `o_tag_wr_en` is high.
- `o_tag_wr_data`  out  TAG_W  always zero (invalid entry).
- `o_cacheable`  out  1  registered cacheable decision for the last accepted access.

## Operation
- States: IDLE, FLUSH, DONE. The index counter `idx` is IW bits wide.
- IDLE:
  - On `i_cache_flush`, go to FLUSH with `idx` = 0.
- FLUSH:
  - Each cycle: `o_tag_wr_en` = 1, `o_tag_wr_addr` = `idx`, then `idx` += 1.
  - When `idx` = LINES-1 has been written, go to DONE. The counter wraps to 0 and never runs past LINES-1.
  - Advances every cycle; `i_core_stall` does not pause the walk.
- DONE (one cycle):
  - `o_flush_done` = 1, `o_flush_busy` = 0.
  - If `pending` is set, clear it and go to FLUSH with `idx` = 0; otherwise go to IDLE.
- `pending` flag:
  - Set by `i_cache_flush` arriving in FLUSH or DONE.
  - Multiple requests collapse into one restart. A request in DONE is treated as pending, so it restarts.
- `o_flush_busy` = 1 exactly while in FLUSH.
- Cacheable decode:
  - Sampled when `!i_core_stall && i_address_valid`.
  - `o_cacheable <= i_cache_enable && i_cacheable_area[i_address[25:21]] && !flush_active`, where `flush_active` = state FLUSH, or a flush strobe this cycle.
  - Otherwise holds its value. Address bits 31:26 are ignored.
- Reset values:
  - State IDLE (FLUSH under the macro), `idx` = 0, `pending` = 0.
  - All outputs 0.
  - Reset mid-walk abandons the walk with no done pulse.

## Timing
- Flush strobe in cycle N:
  - `o_tag_wr_en` and `o_flush_busy` are high in cycles N+1..N+LINES, with addresses 0..LINES-1 in order.
  - `o_flush_done` pulses in cycle N+LINES+1.
- Pending restart: busy is low for exactly the one DONE cycle, then the next walk starts with address 0 in cycle N+LINES+2.
- `o_cacheable` has one-cycle latency from the accepted access.
- All outputs are registered; there are no combinational input-to-output paths.

## Configuration
- `A25_FLUSH_ON_RESET_EN`:
  - Defined: on reset release, the FSM begins in FLUSH at `idx` 0. The first rising edge after reset deassertion writes set 0, and a done pulse follows the walk. This guarantees clean tags at boot.
  - Undefined: the FSM begins in IDLE, and tags are invalidated only by software flush.

## Test plan
- LINES=256, flush strobe at cycle 10 -> writes to addresses 0..255 in cycles 11..266, way mask 4'hF, data 0; done pulse at 267; busy low from 267.
- Second strobe at cycle 100 during that walk -> done at 267; new walk addresses 0..255 in cycles 268..523; done at 524.
- Strobe exactly in the DONE cycle -> treated as pending; walk restarts the next cycle.
- Enable=1, area=32'h0000_0004, address 32'h0040_0010 valid -> `o_cacheable`=1 next cycle; address 32'h0020_0000 -> 0; same access during a walk -> 0; with `i_core_stall`=1 -> value held.
- `i_rst` asserted at walk index 50 -> all outputs 0 immediately (asynchronously), no done pulse; without the macro, stays IDLE after release.
- With `A25_FLUSH_ON_RESET_EN` -> after reset release, 256 writes start on the first clock; done pulse follows.
